// File: rtl/aig_bist_pkg.sv
// Shared types and default constants for the AIG BIST response-compaction path.
package aig_bist_pkg;

    // Run-control states of the response compactor.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } misr_state_e;

    localparam int          RESP_W_DEF = 4;
    localparam int          SIG_W_DEF  = 16;
    localparam int          CNT_W_DEF  = 16;
    localparam logic [15:0] POLY_DEF   = 16'h1021;
    localparam logic [15:0] SEED_DEF   = 16'hFFFF;

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: seed load has priority over a shift step.
// A shift step is a left shift with conditional polynomial feedback, then the
// zero-extended response vector is XORed into the low bits.
module misr_core
    import aig_bist_pkg::*;
#(
    parameter int               RESP_W = RESP_W_DEF,
    parameter int               SIG_W  = SIG_W_DEF,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(POLY_DEF),
    parameter logic [SIG_W-1:0] SEED   = SIG_W'(SEED_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_seed,
    input  logic              shift_en,
    input  logic [RESP_W-1:0] data_in,
    output logic [SIG_W-1:0]  sig
);

    logic [SIG_W-1:0] sig_d;
    logic [SIG_W-1:0] sig_q;

    // Next signature: reload seed, fold in one response, or hold.
    always_comb begin
        sig_d = sig_q;
        if (load_seed) begin
            sig_d = SEED;
        end else if (shift_en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ SIG_W'(data_in);
        end
    end

    // Signature register, seeded on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/aig_resp_misr.sv
// Response compactor for a generated 4-in/4-out benchmark circuit.
// Folds num_patterns response vectors into a MISR and reports the signature.
// Optional build macro MISR_GOLDEN_CMP_EN adds the golden register and the
// pass comparator; without it pass is tied low and golden is ignored.
// Handshake: a response is consumed on a rising clk edge where resp_valid and
// resp_ready are both high; resp_ready is high exactly while the run is active,
// so gaps in resp_valid simply stall the run.
module aig_resp_misr
    import aig_bist_pkg::*;
#(
    parameter int               RESP_W = RESP_W_DEF,
    parameter int               SIG_W  = SIG_W_DEF,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(POLY_DEF),
    parameter logic [SIG_W-1:0] SEED   = SIG_W'(SEED_DEF),
    parameter int               CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_patterns,
    input  logic [SIG_W-1:0]  golden,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp,
    output logic              resp_ready,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature,
    output logic              pass
);

    misr_state_e      state_d, state_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic             ready_d, ready_q;
    logic             busy_d,  busy_q;
    logic             done_d,  done_q;
    logic             load_seed;
    logic             shift_en;
    logic             hs;

    assign hs = resp_valid & ready_q;

    // Next-state, counter and registered-output logic of the run controller.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = done_q;
        load_seed = 1'b0;
        shift_en  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load_seed = 1'b1;
                    count_d   = num_patterns;
                    if (num_patterns == '0) begin
                        state_d = ST_DONE;
                        ready_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                // RUN is only entered with a nonzero count, so this never wraps.
                if (hs) begin
                    shift_en = 1'b1;
                    count_d  = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                        ready_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
                ready_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // Controller state, pattern counter and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    misr_core #(
        .RESP_W (RESP_W),
        .SIG_W  (SIG_W),
        .POLY   (POLY),
        .SEED   (SEED)
    ) u_misr (
        .clk       (clk),
        .rst       (rst),
        .load_seed (load_seed),
        .shift_en  (shift_en),
        .data_in   (resp),
        .sig       (signature)
    );

`ifdef MISR_GOLDEN_CMP_EN
    logic [SIG_W-1:0] golden_d, golden_q;

    // Golden value is captured whenever a run is (re)started.
    always_comb begin
        golden_d = golden_q;
        if (load_seed) begin
            golden_d = golden;
        end
    end

    // Latched golden signature.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            golden_q <= '0;
        end else begin
            golden_q <= golden_d;
        end
    end

    // The signature is frozen in DONE, so the comparison is stable there.
    assign pass = done_q && (signature == golden_q);
`else
    logic unused_golden;
    assign unused_golden = ^golden;
    assign pass          = 1'b0;
`endif

    assign resp_ready = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
